// File: rtl/ball_motion_2d.sv
// rtl/ball_motion_2d.sv - two-axis ball position engine with wall/collision bounce
// Ball centre advances one step every TICK_DIV pixel clocks while running and enabled.
module ball_motion_2d #(
    parameter int POS_W      = 12,
    parameter int SPEED_W    = 3,
    parameter int TICK_DIV   = 800000,
    parameter int X_MIN      = 0,
    parameter int X_MAX      = 1023,
    parameter int Y_MIN      = 0,
    parameter int Y_MAX      = 767,
    parameter int RADIUS     = 10,
    parameter int START_X    = 220,
    parameter int START_Y    = 384,
    parameter int SCORE_MODE = 0
) (
    input  logic               pclk,
    input  logic               reset,
    input  logic               enable,
    input  logic               serve,
    input  logic               serve_dir,
    input  logic [SPEED_W-1:0] speed_x,
    input  logic [SPEED_W-1:0] speed_y,
    input  logic               collision_x,
    input  logic               collision_y,
    output logic [POS_W-1:0]   x_pos,
    output logic [POS_W-1:0]   y_pos,
    output logic               dir_x,
    output logic               dir_y,
    output logic               running,
    output logic               miss_left,
    output logic               miss_right,
    output logic               step
);

    localparam int AW    = POS_W + 1;
    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TICK_DIV - 1);
    localparam logic SCORE = (SCORE_MODE != 0);

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic             wall;
        logic             dir;
        logic [POS_W-1:0] pos;
    } axis_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             col_x;
    logic             col_y;
    axis_t            ax;
    axis_t            ay;

    // Bound tests are rearranged so nothing goes negative: pos+s >= MAX-R and pos <= MIN+R+s.
    function automatic axis_t axis_step(input logic [POS_W-1:0] p, input logic d,
                                        input logic [SPEED_W-1:0] s, input logic col,
                                        input int lo, input int hi);
        axis_t          r;
        logic [AW-1:0]  pe;
        logic [AW-1:0]  se;
        logic [AW-1:0]  lim_lo;
        logic [AW-1:0]  lim_hi;
        pe     = AW'(p);
        se     = AW'(s);
        lim_lo = AW'(lo + RADIUS);
        lim_hi = AW'(hi - RADIUS);
        r.wall = 1'b0;
        r.dir  = d;
        r.pos  = p;
        if (d) begin
            if (pe + se >= lim_hi) begin
                r.wall = 1'b1;
                r.dir  = 1'b0;
                r.pos  = POS_W'(lim_hi);
            end else if (col) begin
                r.dir = 1'b0;
                r.pos = POS_W'(pe - se);
            end else begin
                r.pos = POS_W'(pe + se);
            end
        end else begin
            if (pe <= lim_lo + se) begin
                r.wall = 1'b1;
                r.dir  = 1'b1;
                r.pos  = POS_W'(lim_lo);
            end else if (col) begin
                r.dir = 1'b1;
                r.pos = POS_W'(pe + se);
            end else begin
                r.pos = POS_W'(pe - se);
            end
        end
        return r;
    endfunction

    always_comb begin
        ax = axis_step(x_pos, dir_x, speed_x, col_x | collision_x, X_MIN, X_MAX);
        ay = axis_step(y_pos, dir_y, speed_y, col_y | collision_y, Y_MIN, Y_MAX);
    end

    assign running = (state == RUN);

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            x_pos      <= POS_W'(START_X);
            y_pos      <= POS_W'(START_Y);
            dir_x      <= 1'b1;
            dir_y      <= 1'b1;
            cnt        <= CNT_LOAD;
            col_x      <= 1'b0;
            col_y      <= 1'b0;
            step       <= 1'b0;
            miss_left  <= 1'b0;
            miss_right <= 1'b0;
        end else begin
            step       <= 1'b0;
            miss_left  <= 1'b0;
            miss_right <= 1'b0;
            case (state)
                IDLE: begin
                    cnt   <= CNT_LOAD;
                    col_x <= 1'b0;
                    col_y <= 1'b0;
                    if (serve) begin
                        state <= RUN;
                        dir_x <= serve_dir;
                        dir_y <= 1'b1;
                    end
                end
                RUN: begin
                    col_x <= col_x | collision_x;
                    col_y <= col_y | collision_y;
                    if (enable) begin
                        if (cnt == '0) begin
                            cnt   <= CNT_LOAD;
                            step  <= 1'b1;
                            col_x <= 1'b0;
                            col_y <= 1'b0;
                            // In score mode an x wall is a miss: no bounce, back to serve position.
                            if (SCORE && ax.wall) begin
                                state      <= IDLE;
                                x_pos      <= POS_W'(START_X);
                                y_pos      <= POS_W'(START_Y);
                                miss_left  <= ~dir_x;
                                miss_right <= dir_x;
                            end else begin
                                x_pos <= ax.pos;
                                dir_x <= ax.dir;
                                y_pos <= ay.pos;
                                dir_y <= ay.dir;
                            end
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_motion_2d.sv
// tb/tb_ball_motion_2d.sv - scoreboard bench for ball_motion_2d, bounce and score-mode instances
module tb_ball_motion_2d;

    localparam int TD   = 4;
    localparam int R    = 10;
    localparam int SX   = 220;
    localparam int SY   = 384;
    localparam int XMAX = 1023;
    localparam int YMAX = 767;

    logic        pclk = 1'b0;
    logic        reset;
    logic        enable;
    logic        serve;
    logic        serve_dir;
    logic [2:0]  speed_x;
    logic [2:0]  speed_y;
    logic        collision_x;
    logic        collision_y;

    logic [11:0] x0, y0, x1, y1;
    logic        dx0, dy0, run0, ml0, mr0, st0;
    logic        dx1, dy1, run1, ml1, mr1, st1;

    ball_motion_2d #(.TICK_DIV(TD), .SCORE_MODE(0)) dut0 (
        .pclk(pclk), .reset(reset), .enable(enable), .serve(serve), .serve_dir(serve_dir),
        .speed_x(speed_x), .speed_y(speed_y), .collision_x(collision_x), .collision_y(collision_y),
        .x_pos(x0), .y_pos(y0), .dir_x(dx0), .dir_y(dy0), .running(run0),
        .miss_left(ml0), .miss_right(mr0), .step(st0)
    );

    ball_motion_2d #(.TICK_DIV(TD), .SCORE_MODE(1)) dut1 (
        .pclk(pclk), .reset(reset), .enable(enable), .serve(serve), .serve_dir(serve_dir),
        .speed_x(speed_x), .speed_y(speed_y), .collision_x(collision_x), .collision_y(collision_y),
        .x_pos(x1), .y_pos(y1), .dir_x(dx1), .dir_y(dy1), .running(run1),
        .miss_left(ml1), .miss_right(mr1), .step(st1)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        int cyc;
        int x;
        int y;
        bit dx;
        bit dy;
        bit ml;
        bit mr;
        bit run;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int walls0 = 0;
    int misses1 = 0;

    bit m_run[2];
    int m_ph[2];
    int m_x[2];
    int m_y[2];
    bit m_dx[2];
    bit m_dy[2];
    bit m_cx[2];
    bit m_cy[2];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_run[k] = 1'b0;
            m_ph[k]  = 0;
            m_x[k]   = SX;
            m_y[k]   = SY;
            m_dx[k]  = 1'b1;
            m_dy[k]  = 1'b1;
            m_cx[k]  = 1'b0;
            m_cy[k]  = 1'b0;
        end
        q0.delete();
        q1.delete();
    endtask

    // One axis of one motion step, straight from the bounce rules.
    task automatic move(input int lo, input int hi, input int s, input bit col,
                        inout int p, inout bit d, output bit wall);
        wall = 1'b0;
        if (d) begin
            if (p + R + s >= hi) begin p = hi - R; d = 1'b0; wall = 1'b1; end
            else if (col)         begin p = p - s; d = 1'b0; end
            else                        p = p + s;
        end else begin
            if (p - R - s <= lo) begin p = lo + R; d = 1'b1; wall = 1'b1; end
            else if (col)         begin p = p + s; d = 1'b1; end
            else                        p = p - s;
        end
    endtask

    task automatic model_step(input int k);
        int   nx, ny;
        bit   ndx, ndy, wx, wy;
        exp_t e;
        nx  = m_x[k];
        ny  = m_y[k];
        ndx = m_dx[k];
        ndy = m_dy[k];
        move(0, XMAX, int'(speed_x), m_cx[k], nx, ndx, wx);
        move(0, YMAX, int'(speed_y), m_cy[k], ny, ndy, wy);
        m_cx[k] = 1'b0;
        m_cy[k] = 1'b0;
        m_ph[k] = 0;
        e.ml = 1'b0;
        e.mr = 1'b0;
        if (k == 1 && wx) begin
            e.ml     = !m_dx[k];
            e.mr     = m_dx[k];
            m_run[k] = 1'b0;
            m_x[k]   = SX;
            m_y[k]   = SY;
            misses1++;
        end else begin
            if (k == 0 && wx) walls0++;
            m_x[k]  = nx;
            m_y[k]  = ny;
            m_dx[k] = ndx;
            m_dy[k] = ndy;
        end
        e.cyc = cyc;
        e.x   = m_x[k];
        e.y   = m_y[k];
        e.dx  = m_dx[k];
        e.dy  = m_dy[k];
        e.run = m_run[k];
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    always @(posedge pclk) begin
        cyc++;
        if (!reset) begin
            model_reset();
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (!m_run[k]) begin
                    if (serve) begin
                        m_run[k] = 1'b1;
                        m_dx[k]  = serve_dir;
                        m_dy[k]  = 1'b1;
                        m_ph[k]  = 0;
                    end
                end else begin
                    m_cx[k] = m_cx[k] | collision_x;
                    m_cy[k] = m_cy[k] | collision_y;
                    if (enable) begin
                        if (m_ph[k] == TD - 1) model_step(k);
                        else                   m_ph[k]++;
                    end
                end
            end
        end
    end

    task automatic monitor(input int k, input logic st, input logic ml, input logic mr,
                           input logic run, input logic dx, input logic dy,
                           input logic [11:0] x, input logic [11:0] y);
        exp_t e;
        int   n;
        n = (k == 0) ? q0.size() : q1.size();
        if (n > 0) begin
            e = (k == 0) ? q0.pop_front() : q1.pop_front();
            tests++;
            if (e.cyc != cyc || st !== 1'b1 || ml !== e.ml || mr !== e.mr || run !== e.run ||
                dx !== e.dx || dy !== e.dy || int'(x) != e.x || int'(y) != e.y) begin
                fails++;
                $display("FAIL dut%0d step cyc %0d: got st=%0b x=%0d y=%0d dx=%0b dy=%0b run=%0b ml=%0b mr=%0b, expected step at cyc %0d x=%0d y=%0d dx=%0b dy=%0b run=%0b ml=%0b mr=%0b",
                         k, cyc, st, x, y, dx, dy, run, ml, mr, e.cyc, e.x, e.y, e.dx, e.dy, e.run, e.ml, e.mr);
            end
        end else if (st || ml || mr) begin
            tests++;
            fails++;
            $display("FAIL dut%0d unexpected pulse cyc %0d: got st=%0b ml=%0b mr=%0b expected none",
                     k, cyc, st, ml, mr);
        end
    endtask

    always @(negedge pclk) begin
        if (reset) begin
            monitor(0, st0, ml0, mr0, run0, dx0, dy0, x0, y0);
            monitor(1, st1, ml1, mr1, run1, dx1, dy1, x1, y1);
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, " x0"}, int'(x0), SX);
        check({tag, " y0"}, int'(y0), SY);
        check({tag, " dx0"}, int'(dx0), 1);
        check({tag, " dy0"}, int'(dy0), 1);
        check({tag, " run0"}, int'(run0), 0);
        check({tag, " st0"}, int'(st0), 0);
        check({tag, " x1"}, int'(x1), SX);
        check({tag, " y1"}, int'(y1), SY);
        check({tag, " run1"}, int'(run1), 0);
        check({tag, " miss1"}, int'(ml1 | mr1), 0);
    endtask

    initial begin
        reset       = 1'b0;
        enable      = 1'b1;
        serve       = 1'b0;
        serve_dir   = 1'b1;
        speed_x     = 3'd1;
        speed_y     = 3'd1;
        collision_x = 1'b0;
        collision_y = 1'b0;
        #12;
        check_reset_state("reset");
        @(negedge pclk);
        reset = 1'b1;

        repeat (6) @(negedge pclk);
        check("idle hold x0", int'(x0), SX);
        check("idle hold y0", int'(y0), SY);
        check("idle run0", int'(run0), 0);

        serve = 1'b1;
        @(negedge pclk);
        serve = 1'b0;
        check("serve run0", int'(run0), 1);
        check("serve run1", int'(run1), 1);
        repeat (40) @(negedge pclk);

        repeat (15000) begin
            @(negedge pclk);
            enable      = ($urandom % 16) != 0;
            serve       = ($urandom % 8) == 0;
            serve_dir   = $urandom % 2;
            collision_x = ($urandom % 40) == 0;
            collision_y = ($urandom % 40) == 0;
            if (($urandom % 32) == 0) begin
                speed_x = 3'($urandom_range(0, 7));
                speed_y = 3'($urandom_range(0, 7));
            end
        end

        @(negedge pclk);
        enable      = 1'b1;
        serve       = 1'b1;
        collision_x = 1'b0;
        collision_y = 1'b0;
        speed_y     = 3'd3;
        @(negedge pclk);
        serve = 1'b0;
        @(negedge pclk);
        enable = 1'b0;
        repeat (3) @(negedge pclk);
        collision_y = 1'b1;
        @(negedge pclk);
        collision_y = 1'b0;
        repeat (6) @(negedge pclk);
        enable = 1'b1;
        repeat (12) @(negedge pclk);

        check("bounce walls seen", int'(walls0 > 0), 1);
        check("score misses seen", int'(misses1 > 0), 1);

        @(negedge pclk);
        #2;
        reset = 1'b0;
        #1;
        check_reset_state("async");
        @(negedge pclk);
        #2;
        reset = 1'b1;
        repeat (10) @(negedge pclk);
        check("post-reset run0", int'(run0), 0);
        check("post-reset run1", int'(run1), 0);
        check("post-reset x0", int'(x0), SX);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
